// File: rtl/dmem_pkg.sv
// Shared types, byte-enable constants and the access-fault rule for dmem_responder.
// Alignment faults are only included when DMEM_MISALIGN_CHECK_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // A faulting access returns err with zero data and never touches memory.
    function automatic logic access_fault(input logic [31:0] addr,
                                          input logic [3:0]  be,
                                          input int unsigned depth_log2);
        logic f;
        f = ((addr >> (depth_log2 + 2)) != 32'd0) || (be == 4'b0000);
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((be == BE_WORD) && (addr[1:0] != 2'b00)) f = 1'b1;
        if (((be == BE_HALF_LO) || (be == BE_HALF_HI)) && addr[0]) f = 1'b1;
`endif
        return f;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side load/store request and response bus for dmem_responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables, one synchronous write
// port and a registered read port sharing a single index.
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_be,
    output logic [31:0]           o_rdata
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    // Contents are deliberately never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) mem_q[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_rd_en) rdata_q <= mem_q[i_idx];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE -> WAIT -> RESP -> IDLE.
// Optional alignment faults are enabled with DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [1:0]  o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both 1; valid may not depend on ready and payload is held while valid.
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;
    logic        load_ok_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        direct_fire;
    logic        wait_fire;
    logic        fire;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_fault;
    logic [31:0] arr_rdata;

    // The access is performed on the edge that enters RESP; with LATENCY = 1
    // that is the accepting edge, so the live request fields are used.
    always_comb begin
        direct_fire = (LATENCY == 1) && (state_q == IDLE) && i_req_valid && ready_q;
        wait_fire   = (state_q == WAIT) && (cnt_q <= 4'd1);
        if (direct_fire) begin
            acc_we    = i_req_we;
            acc_addr  = i_req_addr;
            acc_wdata = i_req_wdata;
            acc_be    = i_req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_fault = access_fault(acc_addr, acc_be, DEPTH_LOG2);
        fire      = !i_rst && (direct_fire || wait_fire);
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .i_clk   (i_clk),
        .i_wr_en (fire && acc_we && !acc_fault),
        .i_rd_en (fire && !acc_we && !acc_fault),
        .i_idx   (acc_addr[DEPTH_LOG2+1:2]),
        .i_wdata (acc_wdata),
        .i_be    (acc_be),
        .o_rdata (arr_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid && ready_q) begin
                        we_q    <= i_req_we;
                        addr_q  <= i_req_addr;
                        wdata_q <= i_req_wdata;
                        be_q    <= i_req_be;
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q   <= RESP;
                            valid_q   <= 1'b1;
                            err_q     <= acc_fault;
                            load_ok_q <= !acc_we && !acc_fault;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        state_q   <= RESP;
                        cnt_q     <= 4'd0;
                        valid_q   <= 1'b1;
                        err_q     <= acc_fault;
                        load_ok_q <= !acc_we && !acc_fault;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state_q   <= IDLE;
                        ready_q   <= 1'b1;
                        valid_q   <= 1'b0;
                        err_q     <= 1'b0;
                        load_ok_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = valid_q;
    assign o_rsp_err   = err_q;
    assign o_rsp_rdata = load_ok_q ? arr_rdata : 32'd0;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model,
// plus directed store/load, byte-lane, range, backpressure, reset and alignment cases.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DL2 = 10;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_LOG2 (DL2),
        .LATENCY    (LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (bus.req_valid),
        .o_req_ready (bus.req_ready),
        .i_req_we    (bus.req_we),
        .i_req_addr  (bus.req_addr),
        .i_req_wdata (bus.req_wdata),
        .i_req_be    (bus.req_be),
        .o_rsp_valid (bus.rsp_valid),
        .i_rsp_ready (bus.rsp_ready),
        .o_rsp_rdata (bus.rsp_rdata),
        .o_rsp_err   (bus.rsp_err),
        .o_dbg_state (dbg_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [64];
    logic [32:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_fault(input logic [31:0] addr, input logic [3:0] be);
        logic f;
        f = (addr >= (32'd4 << DL2)) || (be == 4'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (be == 4'd15 && (addr % 4) != 0) f = 1'b1;
        if ((be == 4'd3 || be == 4'd12) && (addr % 2) != 0) f = 1'b1;
`endif
        return f;
    endfunction

    // Expected response {err, rdata}; stores update the model immediately.
    task automatic model_apply(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
        int          idx;
        logic [31:0] mask;
        idx  = int'(addr / 4);
        mask = 32'd0;
        for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
        if (model_fault(addr, be)) begin
            exp_q.push_back({1'b1, 32'd0});
        end else if (we) begin
            model_mem[idx] = (model_mem[idx] & ~mask) | (wdata & mask);
            exp_q.push_back({1'b0, 32'd0});
        end else begin
            exp_q.push_back({1'b0, model_mem[idx]});
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output bit ok);
        int i;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < 20) begin
            if (i > 0) @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
            i++;
        end
        if (!ok) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rd_o, output logic err_o);
        bit          ok;
        bit          got;
        int          lat;
        logic [32:0] exp;
        rd_o  = 32'hX;
        err_o = 1'bX;
        drive_req(we, addr, wdata, be, ok);
        if (!ok) return;
        model_apply(we, addr, wdata, be);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) got = 1'b1;
            else chk("req_ready_while_wait", bus.req_ready, 0);
        end
        if (!got) begin
            chk("rsp_timeout", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        chk("latency", lat, LAT);
        exp   = exp_q.pop_front();
        rd_o  = bus.rsp_rdata;
        err_o = bus.rsp_err;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid_hold", bus.rsp_valid, 1);
            chk("rsp_rdata", bus.rsp_rdata, exp[31:0]);
            chk("rsp_err", bus.rsp_err, exp[32]);
            chk("req_ready_in_resp", bus.req_ready, 0);
            chk("state_resp", dbg_state, RESP);
            if (h == hold) bus.rsp_ready = 1'b1;
            @(posedge clk);
            if (h < hold) @(negedge clk);
        end
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_valid_after", bus.rsp_valid, 0);
        chk("rsp_rdata_idle", bus.rsp_rdata, 0);
        chk("rsp_err_idle", bus.rsp_err, 0);
        chk("req_ready_after", bus.req_ready, 1);
        chk("state_idle", dbg_state, IDLE);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] old30;
        logic [31:0] old40;
        logic [31:0] addr;
        bit          ok;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_be    = 4'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_state", dbg_state, IDLE);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) do_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, err);

        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, err);
        do_txn(1'b0, 32'h10, 32'd0, 4'hF, 0, rd, err);
        chk("st_ld_rdata", rd, 32'hDEADBEEF);
        chk("st_ld_err", err, 0);

        do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, err);
        do_txn(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0, rd, err);
        do_txn(0, 32'h20, 32'd0, 4'hF, 0, rd, err);
        chk("byte_lane_rdata", rd, 32'h1122AA44);

        do_txn(1'b0, 32'h1000, 32'd0, 4'hF, 0, rd, err);
        chk("oor_load_err", err, 1);
        chk("oor_load_rdata", rd, 0);
        do_txn(1'b1, 32'h1010, 32'h0BADF00D, 4'hF, 0, rd, err);
        chk("oor_store_err", err, 1);
        do_txn(1'b1, 32'h20, 32'h0, 4'b0000, 0, rd, err);
        chk("be_zero_err", err, 1);

        do_txn(1'b0, 32'h10, 32'd0, 4'hF, 5, rd, err);
        chk("backpressure_rdata", rd, 32'hDEADBEEF);

        old30 = model_mem[12];
        drive_req(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, ok);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_rsp_valid", bus.rsp_valid, 0);
        chk("rst_wait_req_ready", bus.req_ready, 1);
        chk("rst_wait_state", dbg_state, IDLE);
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait_no_rsp", bus.rsp_valid, 0);
        end
        do_txn(1'b0, 32'h30, 32'd0, 4'hF, 0, rd, err);
        chk("rst_wait_old_value", rd, old30);

        old40 = model_mem[16];
        do_txn(1'b1, 32'h42, 32'h5A5A5A5A, 4'hF, 0, rd, err);
        do_txn(1'b0, 32'h40, 32'd0, 4'hF, 0, rd, err);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("misalign_no_write", rd, old40);
`else
        chk("misalign_ignored_write", rd, 32'h5A5A5A5A);
`endif

        for (int t = 0; t < 200; t++) begin
            addr = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'd1 << $urandom_range(12, 31));
            do_txn(1'($urandom), addr, $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), rd, err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit memory words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to o_rsp_valid (legal range 1..15).
REQ-003 SHALL have port i_clk  input  1  meaning single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port i_req_valid  input  1  meaning core presents a load/store request.
REQ-006 SHALL have port o_req_ready  output  1  meaning responder can accept a request.
REQ-007 SHALL have port i_req_we  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port i_req_addr  input  32  meaning byte address.
REQ-009 SHALL have port i_req_wdata  input  32  meaning store data, already lane-aligned.
REQ-010 SHALL have port i_req_be  input  4  meaning byte enables, bit n = byte lane n.
REQ-011 SHALL have port o_rsp_valid  output  1  meaning response available.
REQ-012 SHALL have port i_rsp_ready  input  1  meaning core consumes the response.
REQ-013 SHALL have port o_rsp_rdata  output  32  meaning full word read, or 0 for stores and errors.
REQ-014 SHALL have port o_rsp_err  output  1  meaning access faulted; no memory side effect.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, with o_req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where i_req_valid & o_req_ready, registering we/addr/wdata/be and going to WAIT, or to RESP directly when LATENCY = 1.
REQ-017 SHALL count down in WAIT with a 4-bit counter loaded with LATENCY-1 and enter RESP at the edge where the counter reaches 0, so o_rsp_valid rises exactly LATENCY cycles after acceptance.
REQ-018 SHALL perform a store on the edge entering RESP: write bytes whose be bit = 1 into word addr[DEPTH_LOG2+1:2], leave other bytes unchanged, and return rdata 0.
REQ-019 SHALL capture the read word on the edge entering RESP for a load, so a load that follows a store to the same word returns the stored data.
REQ-020 SHALL flag an error for out-of-range addresses (any addr bit above DEPTH_LOG2+1 set): err = 1, rdata = 0, no write.
REQ-021 SHALL flag an error for be = 4'b0000: err = 1, rdata = 0, no write.
REQ-022 SHALL hold o_rsp_valid, o_rsp_rdata and o_rsp_err stable in RESP until i_rsp_ready = 1, then return to IDLE on that edge.
REQ-023 SHALL leave o_req_ready = 0 on the cycle of the consuming edge, i.e. there is no same-cycle back-to-back accept and the minimum request spacing is LATENCY+1 cycles.
REQ-024 SHALL drive o_rsp_rdata and o_rsp_err to 0 whenever o_rsp_valid = 0.

Reset
REQ-025 SHALL, while i_rst = 1 at a rising edge, force state IDLE, counter 0, o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0 and o_req_ready 1 after the edge.
REQ-026 SHALL, on reset asserted in WAIT, abandon the pending access with no write and no response.
REQ-027 SHALL NOT clear memory contents on reset; initial contents are unspecified unless preloaded by the bench via hierarchical $readmemh.

Configuration
REQ-028 SHALL, with macro DMEM_MISALIGN_CHECK_EN defined, set err = 1 with no write and rdata 0 when be = 4'b1111 and addr[1:0] != 0, or when be is 4'b0011 or 4'b1100 and addr[0] != 0.
REQ-029 SHALL, without DMEM_MISALIGN_CHECK_EN, ignore addr[1:0] and apply be to the addressed word with no alignment error.

Structure
REQ-030 SHALL place the FSM state enum (IDLE/WAIT/RESP) and byte-enable constants (BE_WORD = 4'b1111, BE_HALF_LO = 4'b0011, BE_HALF_HI = 4'b1100) in shared package dmem_pkg.
REQ-031 SHALL isolate the storage array and byte-lane write logic in sub-module dmem_array, with a single synchronous write port and a registered read port.

Verification
REQ-032 SHALL cover store-then-load at LATENCY = 2: store 0xDEADBEEF, be 1111, addr 0x10, then load addr 0x10 -> each rsp_valid arrives 2 cycles after accept; load rdata = 0xDEADBEEF, err = 0.
REQ-033 SHALL cover a byte-lane store: preload 0x11223344 at addr 0x20, store wdata 0x0000AA00 with be 0010 -> a subsequent load returns 0x1122AA44.
REQ-034 SHALL cover out-of-range access: load addr 0x00001000 with DEPTH_LOG2 = 10 -> err = 1, rdata = 0, and memory is unchanged.
REQ-035 SHALL cover backpressure: hold i_rsp_ready = 0 for 5 cycles in RESP -> rsp_valid/rdata stay stable, o_req_ready stays 0, and the FSM returns to IDLE only on the first edge with ready = 1.
REQ-036 SHALL cover reset in WAIT: assert i_rst one cycle after accepting a store of 0xCAFEF00D to addr 0x30 -> no response, o_req_ready = 1 after the edge, and a later load of 0x30 returns the old value.
REQ-037 SHALL cover misalignment with DMEM_MISALIGN_CHECK_EN defined: word store at addr 0x42 -> err = 1 and no write; without the macro the same store writes word 0x40.
